serial_frame_tx: RTL

- Transmit end of the serial bit-stream interface that the Moore/Mealy sequence detectors and counters consume on their 1-bit `in` input.
- Accepts a parallel word with a one-cycle start strobe and serialises it as a frame on a single registered output: start bit, DATA_W data bits, stop bit.
- Exposes `state` and `next_state` for waveform inspection, as the lab FSM blocks do.
- Sits upstream of a detector instance in the lab top level and in the test bench.

---
 rtl/serial_tx_pkg.sv | 14 +
 rtl/tx_shift_reg.sv | 39 +++
 rtl/serial_frame_tx.sv | 85 ++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// Shared encodings for the serial frame transmitter: FSM states and bit-order modes.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } state_t;

  localparam logic MODE_MSB_FIRST = 1'b0;
  localparam logic MODE_LSB_FIRST = 1'b1;

endpackage

// File: rtl/tx_shift_reg.sv
// Payload shift register: loads a word with its bit order, presents the head bit,
// and advances one bit per shift toward the head.
module tx_shift_reg
  import serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              dir,
  input  logic [DATA_W-1:0] d,
  output logic              head
);

  logic [DATA_W-1:0] r_q;
  logic              r_dir;

  // Bit order is latched with the word so later mode changes cannot disturb it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q   <= '0;
      r_dir <= MODE_MSB_FIRST;
    end else if (load) begin
      r_q   <= d;
      r_dir <= dir;
    end else if (shift) begin
      if (r_dir == MODE_MSB_FIRST) begin
        r_q <= {r_q[DATA_W-2:0], 1'b0};
      end else begin
        r_q <= {1'b0, r_q[DATA_W-1:1]};
      end
    end
  end

  assign head = (r_dir == MODE_MSB_FIRST) ? r_q[DATA_W-1] : r_q[0];

endmodule

// File: rtl/serial_frame_tx.sv
// Serialises a parallel word as start bit, DATA_W data bits, stop bit on one line.
// out/busy/done are registered decodes of state, so they trail state by one cycle.
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          START_LVL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              mode,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state,
  output logic [1:0]        next_state
);

  localparam int unsigned     CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_shift;
  logic             w_head;

  assign w_load  = start && ((r_state == ST_IDLE) || (r_state == ST_STOP));
  assign w_shift = (r_state == ST_DATA);

  tx_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .dir   (mode),
    .d     (data),
    .head  (w_head)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_START;
      ST_START: w_next = ST_DATA;
      ST_DATA:  if (r_cnt == CNT_LAST) w_next = ST_STOP;
      ST_STOP:  w_next = start ? ST_START : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Line and status flops decode the current state, never the inputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      out     <= ~START_LVL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DATA) begin
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : CNT_W'(r_cnt + 1'b1);
      end else begin
        r_cnt <= '0;
      end
      case (r_state)
        ST_START: out <= START_LVL;
        ST_DATA:  out <= w_head;
        default:  out <= ~START_LVL;
      endcase
      busy <= (r_state != ST_IDLE);
      done <= (r_state == ST_STOP);
    end
  end

  assign state      = r_state;
  assign next_state = w_next;

endmodule
